// File: rtl/lsq_dmem_responder.sv
// Data-memory responder for the LSQ port: one load/store per request against a word RAM, optional alignment check (LSQ_DMEM_ALIGN_CHK_EN).
// Latency: request sampled at edge N, completion pulse (rd_ready/wr_ready, err) visible in the cycle after edge N+LAT.
// Backpressure: none; busy is high while an access is in flight and requests arriving then are dropped.
module lsq_dmem_responder #(
  parameter int DEPTH_W = 10,
  parameter int LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data_in,
  output logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t             r_state, w_next;
  logic [3:0]         r_cnt, w_cnt_next;
  logic [5:0]         r_op;
  logic [31:0]        r_addr, r_wdata;
  logic [31:0]        r_mem [0:(1<<DEPTH_W)-1];
  logic [31:0]        r_rdword;
  logic               r_rd_ready, r_wr_ready, r_err;
  logic [31:0]        r_rd_data;
  logic               w_capture, w_enter;

  // Next-state: IDLE and RESP both accept a request; WAIT counts down to RESP.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    w_enter    = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (op_in != 6'd0) begin
          w_capture = 1'b1;
          if (LAT == 1) begin
            w_next  = S_RESP;
            w_enter = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LAT_M1;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next  = S_RESP;
          w_enter = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, countdown and captured request registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 6'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_op    <= op_in;
        r_addr  <= addr_in;
        r_wdata <= wr_data_in;
      end
    end
  end

  // The RAM is accessed on the RESP-entry edge; with LAT==1 that is the capture edge itself.
  logic [5:0]         w_a_op;
  logic [31:0]        w_a_addr, w_a_data;
  logic [1:0]         w_a_sz;
  logic               w_a_mis;
  logic [3:0]         w_be;
  logic [31:0]        w_wdat;
  logic [DEPTH_W-1:0] w_idx;

  assign w_a_op   = (LAT == 1) ? op_in      : r_op;
  assign w_a_addr = (LAT == 1) ? addr_in    : r_addr;
  assign w_a_data = (LAT == 1) ? wr_data_in : r_wdata;
  assign w_a_sz   = w_a_op[1:0];
  assign w_idx    = w_a_addr[DEPTH_W+1:2];

`ifdef LSQ_DMEM_ALIGN_CHK_EN
  assign w_a_mis = ((w_a_sz == 2'b10) && w_a_addr[0]) ||
                   ((w_a_sz[1] == w_a_sz[0]) && (w_a_addr[1:0] != 2'b00));
`else
  assign w_a_mis = 1'b0;
`endif

  // Byte enables and lane-replicated store data; size 00 behaves as a word.
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = w_a_data;
    if (w_a_sz == 2'b01) begin
      w_be   = 4'b0001 << w_a_addr[1:0];
      w_wdat = {4{w_a_data[7:0]}};
    end else if (w_a_sz == 2'b10) begin
      w_be   = w_a_addr[1] ? 4'b1100 : 4'b0011;
      w_wdat = {2{w_a_data[15:0]}};
    end
  end

  // RAM: byte-enabled write for stores, registered read for loads. A reset on
  // the entry edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && w_enter) begin
      r_rdword <= r_mem[w_idx];
      if (w_a_op[3] && !w_a_mis) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
      end
    end
  end

  // Load extraction in the RESP cycle from the registered word and captured request.
  logic [31:0] w_lane, w_ext;
  logic [15:0] w_half;
  logic        w_r_mis;

  assign w_lane = r_rdword >> {r_addr[1:0], 3'b000};
  assign w_half = r_addr[1] ? r_rdword[31:16] : r_rdword[15:0];

`ifdef LSQ_DMEM_ALIGN_CHK_EN
  assign w_r_mis = ((r_op[1:0] == 2'b10) && r_addr[0]) ||
                   ((r_op[1] == r_op[0]) && (r_addr[1:0] != 2'b00));
`else
  assign w_r_mis = 1'b0;
`endif

  // Sign/zero extension; word (and size 00) loads ignore the unsigned bit.
  always_comb begin
    w_ext = r_rdword;
    if (r_op[1:0] == 2'b01)
      w_ext = r_op[2] ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
    else if (r_op[1:0] == 2'b10)
      w_ext = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
  end

  // Completion outputs: one-cycle pulse after the RESP cycle; rd_data holds between completions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= 32'd0;
    end else if (r_state == S_RESP) begin
      r_rd_ready <= !r_op[3];
      r_wr_ready <= r_op[3];
      r_err      <= w_r_mis;
      r_rd_data  <= (r_op[3] || w_r_mis) ? 32'd0 : w_ext;
    end else begin
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
      r_err      <= 1'b0;
    end
  end

  assign rd_ready = r_rd_ready;
  assign wr_ready = r_wr_ready;
  assign err      = r_err;
  assign rd_data  = r_rd_data;
  assign busy     = (r_state == S_WAIT);

  // Address bits above the RAM index and op bits [5:4] carry no meaning here.
  logic w_unused;
  assign w_unused = ^{w_a_op[5:4], w_a_addr[31:DEPTH_W+2]};

endmodule

// File: tb/tb_lsq_dmem_responder.sv
module tb_lsq_dmem_responder;
  localparam int LAT = 2;
`ifdef LSQ_DMEM_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  localparam logic [5:0] LB = 6'h01, LH = 6'h02, LW = 6'h03, LBU = 6'h05, LHU = 6'h06;
  localparam logic [5:0] SB = 6'h09, SH = 6'h0A, SW = 6'h0B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  op_in = 6'd0;
  logic [31:0] addr_in = 32'd0, wr_data_in = 32'd0;
  logic        rd_ready, wr_ready, busy, err;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  lsq_dmem_responder #(.DEPTH_W(10), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .addr_in(addr_in), .wr_data_in(wr_data_in),
    .rd_ready(rd_ready), .rd_data(rd_data), .wr_ready(wr_ready), .busy(busy), .err(err)
  );

  typedef struct {
    bit          st;
    logic [31:0] d;
    bit          e;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0, n_pass = 0, n_tot = 0, n_push = 0, n_seen = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pop and compare on every completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rd_ready || wr_ready) begin
      n_seen++;
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("kind_wr_ready", {31'd0, wr_ready}, {31'd0, e.st});
        chk("one_hot", {31'd0, rd_ready & wr_ready}, 32'd0);
        chk("rd_data", rd_data, e.d);
        chk("err", {31'd0, err}, {31'd0, e.e});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one request for one cycle; acc=1 pushes the expected completion.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input bit acc, input logic [31:0] exp_d, input bit exp_e);
    exp_t e;
    op_in = op; addr_in = a; wr_data_in = d;
    if (acc) begin
      e.st = op[3]; e.d = exp_d; e.e = exp_e; e.cyc = cyc + 1 + LAT;
      q.push_back(e);
      n_push++;
    end
    @(posedge clk); #1;
    op_in = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b0;
    idle(3);
    chk("reset_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    idle(1);

    // Store then load back.
    drive(SW, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0); idle(LAT);
    drive(LW, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0); idle(LAT);

    // Byte merge and signed/unsigned byte load.
    drive(SW, 32'h10, 32'h11223344, 1, 32'h0, 0); idle(LAT);
    drive(SB, 32'h11, 32'h000000A5, 1, 32'h0, 0); idle(LAT);
    drive(LW, 32'h10, 32'h0, 1, 32'h1122A544, 0); idle(LAT);
    drive(LB, 32'h11, 32'h0, 1, 32'hFFFFFFA5, 0); idle(LAT);
    drive(LBU, 32'h11, 32'h0, 1, 32'h000000A5, 0); idle(LAT);

    // Request while busy is dropped; request in the RESP cycle is accepted.
    drive(LW, 32'h10, 32'h0, 1, 32'h1122A544, 0);
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    drive(LW, 32'h14, 32'h0, 0, 32'h0, 0);
    drive(LB, 32'h11, 32'h0, 1, 32'hFFFFFFA5, 0);
    idle(LAT);

    // Reset during WAIT drops the completion and suppresses the write.
    drive(SW, 32'h20, 32'hCAFEF00D, 1, 32'h0, 0); idle(LAT);
    drive(SW, 32'h20, 32'h00000001, 0, 32'h0, 0);
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    idle(1);
    chk("midreset_rd_data", rd_data, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_ready", {30'd0, rd_ready, wr_ready}, 32'd0);
    chk("midreset_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    idle(LAT + 1);
    drive(LW, 32'h20, 32'h0, 1, 32'hCAFEF00D, 0); idle(LAT);

    // Half and byte extraction.
    drive(SW, 32'h20, 32'h80010000, 1, 32'h0, 0); idle(LAT);
    drive(LH, 32'h22, 32'h0, 1, 32'hFFFF8001, 0); idle(LAT);
    drive(LHU, 32'h22, 32'h0, 1, 32'h00008001, 0); idle(LAT);
    drive(LB, 32'h23, 32'h0, 1, 32'hFFFFFF80, 0); idle(LAT);
    drive(LH, 32'h20, 32'h0, 1, 32'h00000000, 0); idle(LAT);

    // Size 00 behaves as a word; half store merge.
    drive(6'h08, 32'h30, 32'h12345678, 1, 32'h0, 0); idle(LAT);
    drive(6'h04, 32'h30, 32'h0, 1, 32'h12345678, 0); idle(LAT);
    drive(SH, 32'h32, 32'h0000BEEF, 1, 32'h0, 0); idle(LAT);
    drive(LW, 32'h30, 32'h0, 1, 32'hBEEF5678, 0); idle(LAT);

    // Misaligned access and address aliasing.
    drive(SW, 32'h10, 32'h55667788, 1, 32'h0, 0); idle(LAT);
    drive(SW, 32'h13, 32'hAABBCCDD, 1, 32'h0, ALN); idle(LAT);
    drive(LW, 32'h10, 32'h0, 1, ALN ? 32'h55667788 : 32'hAABBCCDD, 0); idle(LAT);
    drive(SW, 32'h1010, 32'h0BADF00D, 1, 32'h0, 0); idle(LAT);
    drive(LW, 32'h10, 32'h0, 1, 32'h0BADF00D, 0); idle(LAT);
    drive(LW, 32'h12, 32'h0, 1, ALN ? 32'h0 : 32'h0BADF00D, ALN); idle(LAT);

    for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
    chk("queue_drained", q.size(), 32'd0);
    idle(3);
    chk("pulse_count", n_seen, n_push);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
